// File: rtl/cipher_iter_engine.sv
// Iterative reversible round engine: rotate-and-xor rounds with a rotating key,
// ROUNDS cycles per block, encrypt and decrypt modes, busy/done/ready handshake.
module cipher_iter_engine #(
  parameter int WIDTH  = 64,
  parameter int ROUNDS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             decrypt,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] key_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             state_dbg
);

  // Handshake: a block is accepted on a rising edge where load=1 and ready=1
  // (ready = ~busy). done pulses for exactly one cycle when data_out updates,
  // and ready is already high in that cycle so the next load is accepted.

  localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int SW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(ROUNDS - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] key_q;
  logic             dec_q;
  logic [CW-1:0]    cnt;

  logic [SW-1:0]    rot_amt;
  logic [WIDTH-1:0] round_key;
  logic [WIDTH-1:0] enc_d;
  logic [WIDTH-1:0] dec_t;
  logic [WIDTH-1:0] dec_d;
  logic [WIDTH-1:0] round_out;
  logic             last_round;

  always_comb begin
    // Round index is reduced mod WIDTH so key rotation wraps when ROUNDS > WIDTH.
    rot_amt    = SW'(32'(cnt) % WIDTH);
    round_key  = (key_q << rot_amt) | (key_q >> (WIDTH - int'(rot_amt)));
    enc_d      = {d_q[WIDTH-2:0], d_q[WIDTH-1]} ^ round_key;
    dec_t      = d_q ^ round_key;
    dec_d      = {dec_t[0], dec_t[WIDTH-1:1]};
    round_out  = dec_q ? dec_d : enc_d;
    last_round = dec_q ? (cnt == '0) : (cnt == LAST_CNT);
  end

  assign ready     = ~busy;
  assign state_dbg = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      d_q      <= '0;
      key_q    <= '0;
      dec_q    <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            d_q   <= data_in;
            key_q <= key_in;
            dec_q <= decrypt;
            cnt   <= decrypt ? LAST_CNT : '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          d_q <= round_out;
          cnt <= dec_q ? (cnt - CW'(1)) : (cnt + CW'(1));
          if (last_round) begin
            data_out <= round_out;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_iter_engine.sv
// Bench for cipher_iter_engine: three instances (8/2, 64/16, 4/9) checked
// against a loop-based reference model of the round function.
module tb_cipher_iter_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_req = 1'b0;
  logic        decrypt = 1'b0;
  logic [63:0] din = '0;
  logic [63:0] key = '0;
  int          sel = 0;

  logic load8, load64, load4;
  logic ready8, busy8, done8, st8;
  logic ready64, busy64, done64, st64;
  logic ready4, busy4, done4, st4;
  logic [7:0]  dout8;
  logic [63:0] dout64;
  logic [3:0]  dout4;

  logic        obs_done, obs_busy, obs_ready;
  logic [63:0] obs_dout;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  assign load8  = load_req && (sel == 0);
  assign load64 = load_req && (sel == 1);
  assign load4  = load_req && (sel == 2);

  cipher_iter_engine #(.WIDTH(8), .ROUNDS(2)) u8 (
    .clk(clk), .reset(reset), .load(load8), .decrypt(decrypt),
    .data_in(din[7:0]), .key_in(key[7:0]), .ready(ready8), .busy(busy8),
    .done(done8), .data_out(dout8), .state_dbg(st8));

  cipher_iter_engine #(.WIDTH(64), .ROUNDS(16)) u64 (
    .clk(clk), .reset(reset), .load(load64), .decrypt(decrypt),
    .data_in(din), .key_in(key), .ready(ready64), .busy(busy64),
    .done(done64), .data_out(dout64), .state_dbg(st64));

  cipher_iter_engine #(.WIDTH(4), .ROUNDS(9)) u4 (
    .clk(clk), .reset(reset), .load(load4), .decrypt(decrypt),
    .data_in(din[3:0]), .key_in(key[3:0]), .ready(ready4), .busy(busy4),
    .done(done4), .data_out(dout4), .state_dbg(st4));

  always_comb begin
    obs_done  = done64;
    obs_busy  = busy64;
    obs_ready = ready64;
    obs_dout  = dout64;
    case (sel)
      0: begin obs_done = done8; obs_busy = busy8; obs_ready = ready8; obs_dout = {56'd0, dout8}; end
      2: begin obs_done = done4; obs_busy = busy4; obs_ready = ready4; obs_dout = {60'd0, dout4}; end
      default: ;
    endcase
  end

  function automatic int width_of(input int s);
    return (s == 0) ? 8 : (s == 2) ? 4 : 64;
  endfunction

  function automatic int rounds_of(input int s);
    return (s == 0) ? 2 : (s == 2) ? 9 : 16;
  endfunction

  function automatic logic [63:0] mask_of(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] rotl_m(input logic [63:0] v, input int s, input int w);
    logic [63:0] m;
    int          a;
    m = mask_of(w);
    v = v & m;
    a = s % w;
    if (a == 0) return v;
    return ((v << a) | (v >> (w - a))) & m;
  endfunction

  function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] k,
                                        input int s, input bit dec);
    logic [63:0] d;
    int          w, r;
    w = width_of(s);
    r = rounds_of(s);
    d = x & mask_of(w);
    if (!dec) begin
      for (int i = 0; i < r; i++) d = rotl_m(d, 1, w) ^ rotl_m(k, i, w);
    end else begin
      for (int i = r - 1; i >= 0; i--) d = rotl_m(d ^ rotl_m(k, i, w), w - 1, w);
    end
    return d;
  endfunction

  // Loads one block, scrambles inputs (including stray loads) while it runs,
  // and returns the result plus the number of edges from load to done.
  task automatic run_block(input int s, input logic [63:0] x, input logic [63:0] k,
                           input bit dec, output logic [63:0] res, output int lat,
                           output logic busy_after_load);
    sel = s;
    @(negedge clk);
    din = x; key = k; decrypt = dec; load_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    busy_after_load = obs_busy;
    lat = 0;
    while (!obs_done && lat < 100) begin
      din = {$urandom, $urandom}; key = {$urandom, $urandom};
      decrypt = 1'($urandom_range(0, 1)); load_req = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    load_req = 1'b0;
    res = obs_dout;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      vectors++;
      if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_dout !== 64'd0 || obs_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_state sel=%0d busy=%b done=%b ready=%b dout=%h required 0/0/1/0",
                 s, obs_busy, obs_done, obs_ready, obs_dout);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_encrypt_small;
    logic [63:0] res; int lat; logic b;
    run_block(0, 64'h80, 64'h01, 1'b0, res, lat, b);
    vectors++;
    if (b !== 1'b1) begin miscompares++; $display("FAIL enc8_busy got %b required 1", b); end
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL enc8_latency got %0d required 2", lat); end
    vectors++;
    if (res !== 64'h02) begin miscompares++; $display("FAIL enc8_data got %h required 02", res); end
    vectors++;
    if (obs_busy !== 1'b0) begin miscompares++; $display("FAIL enc8_busy_at_done got %b required 0", obs_busy); end
  endtask

  task automatic test_decrypt_small;
    logic [63:0] res; int lat; logic b;
    run_block(0, 64'h02, 64'h01, 1'b1, res, lat, b);
    vectors++;
    if (lat !== 2 || res !== 64'h80) begin
      miscompares++; $display("FAIL dec8 got lat=%0d data=%h required lat=2 data=80", lat, res);
    end
    @(negedge clk);
    vectors++;
    if (obs_done !== 1'b0) begin miscompares++; $display("FAIL dec8_pulse done=%b required 0", obs_done); end
    vectors++;
    if (obs_dout !== 64'h80) begin miscompares++; $display("FAIL dec8_hold got %h required 80", obs_dout); end
  endtask

  task automatic test_round_trip;
    logic [63:0] x, k, c, p; int lat; logic b;
    for (int n = 0; n < 200; n++) begin
      x = {$urandom, $urandom}; k = {$urandom, $urandom};
      run_block(1, x, k, 1'b0, c, lat, b);
      vectors++;
      if (lat !== 16 || c !== model(x, k, 1, 1'b0)) begin
        miscompares++;
        $display("FAIL rt_encrypt n=%0d lat=%0d data=%h required lat=16 data=%h", n, lat, c, model(x, k, 1, 1'b0));
      end
      run_block(1, c, k, 1'b1, p, lat, b);
      vectors++;
      if (lat !== 16 || p !== x) begin
        miscompares++;
        $display("FAIL rt_decrypt n=%0d lat=%0d data=%h required lat=16 data=%h", n, lat, p, x);
      end
    end
  endtask

  task automatic test_back_to_back;
    int last_acc, accepts;
    logic [63:0] got;
    sel = 1;
    last_acc = -1;
    accepts = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (obs_done) begin
        got = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
        vectors++;
        if (obs_dout !== got) begin
          miscompares++; $display("FAIL b2b_data cycle=%0d got %h required %h", c, obs_dout, got);
        end
      end
      din = {$urandom, $urandom}; key = {$urandom, $urandom};
      decrypt = 1'($urandom_range(0, 1));
      load_req = (c < 119);
      if (load_req && obs_ready) begin
        if (last_acc >= 0) begin
          vectors++;
          if (c - last_acc !== 17) begin
            miscompares++; $display("FAIL b2b_spacing got %0d required 17", c - last_acc);
          end
        end
        last_acc = c;
        accepts++;
        exp_q.push_back(model(din, key, 1, decrypt));
      end
    end
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (obs_done) begin
        got = exp_q.pop_front();
        vectors++;
        if (obs_dout !== got) begin
          miscompares++; $display("FAIL b2b_drain got %h required %h", obs_dout, got);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0 || accepts != 7) begin
      miscompares++;
      $display("FAIL b2b_count pending=%0d accepts=%0d required 0 and 7", exp_q.size(), accepts);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    int seen;
    logic [63:0] res; int lat; logic b;
    sel = 1;
    @(negedge clk);
    din = 64'h0123_4567_89AB_CDEF; key = 64'hFEDC_BA98_7654_3210; decrypt = 1'b0; load_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_req = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_dout !== 64'd0) begin
      miscompares++;
      $display("FAIL mid_reset busy=%b done=%b dout=%h required 0/0/0", obs_busy, obs_done, obs_dout);
    end
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (obs_done) seen++;
    end
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL mid_reset_ghost_done got %0d required 0", seen); end
    run_block(1, 64'd0, 64'd0, 1'b0, res, lat, b);
    vectors++;
    if (lat !== 16 || res !== 64'd0) begin
      miscompares++; $display("FAIL post_reset_zero lat=%0d data=%h required lat=16 data=0", lat, res);
    end
  endtask

  task automatic test_key_wrap;
    logic [63:0] x, k, c, p; int lat; logic b;
    run_block(2, 64'h0, 64'h1, 1'b0, c, lat, b);
    vectors++;
    if (c !== 64'h1 || lat !== 9) begin
      miscompares++; $display("FAIL wrap_encrypt data=%h lat=%0d required data=1 lat=9", c, lat);
    end
    run_block(2, c, 64'h1, 1'b1, p, lat, b);
    vectors++;
    if (p !== 64'h0) begin miscompares++; $display("FAIL wrap_decrypt got %h required 0", p); end
    for (int n = 0; n < 12; n++) begin
      x = 64'($urandom_range(0, 15)); k = 64'($urandom_range(0, 15));
      run_block(2, x, k, 1'b0, c, lat, b);
      vectors++;
      if (c !== model(x, k, 2, 1'b0)) begin
        miscompares++; $display("FAIL wrap_model x=%h k=%h got %h required %h", x, k, c, model(x, k, 2, 1'b0));
      end
      run_block(2, c, k, 1'b1, p, lat, b);
      vectors++;
      if (p !== x) begin miscompares++; $display("FAIL wrap_trip x=%h k=%h got %h", x, k, p); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_encrypt_small();
    test_decrypt_small();
    test_round_trip();
    test_back_to_back();
    test_reset_mid();
    test_key_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cipher_iter_engine.md
Name: cipher_iter_engine

Overview:
- Synthesizable, parametrised successor to the file-driven DES top-level stub.
- An iterative round engine with the same load/data/key contract, plus a real deterministic, reversible transform, configurable width and round count, and an encrypt/decrypt mode.
- Has busy/done/ready handshake.
- Sits under the cipher top as a drop-in core for system bring-up before the full DES datapath lands.

Parameters:
- WIDTH, 64, data and key width in bits (>= 2).
- ROUNDS, 16, rounds per block (>= 1); also the load-to-done latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  start request; accepted only when ready=1.
- decrypt  input  1  mode captured at accepted load; 0=encrypt, 1=decrypt.
- data_in  input  WIDTH  block captured at accepted load.
- key_in  input  WIDTH  key captured at accepted load.
- ready  output  1  combinational, equals ~busy.
- busy  output  1  high while rounds execute.
- done  output  1  one-cycle pulse when data_out is updated.
- data_out  output  WIDTH  result register; holds until the next done.

Behaviour:
- Reset is synchronous, on a clk edge with reset=1:
  - busy=0, done=0, data_out=0.
  - Internal state, key and round-counter registers are cleared.
  - Reset has priority over load and over any round in progress.
  - A block in flight is discarded and produces no done.
- Round key: k_i = rotl(key, i mod WIDTH), for i = 0..ROUNDS-1.
- Encrypt round i: d <= rotl(d,1) XOR k_i.
  - Rounds run with i ascending, 0 -> ROUNDS-1.
- Decrypt round i: d <= rotr(d XOR k_i, 1).
  - Rounds run with i descending, ROUNDS-1 -> 0.
- All arithmetic is bitwise, WIDTH bits, with no carries.
- Rotation amount i mod WIDTH is handled correctly when ROUNDS > WIDTH.
- Accepted load (load=1 and busy=0 at the edge):
  - capture data_in, key_in and decrypt;
  - set the counter to 0 for encrypt, ROUNDS-1 for decrypt;
  - busy <= 1.
  - No round is applied on the load edge.
- State machine IDLE/RUN:
  - IDLE -> RUN on an accepted load.
  - In RUN, each edge applies one round and steps the counter (+1 for encrypt, -1 for decrypt).
  - The edge applying the final round (the ROUNDS-th) does all of: data_out <= result, done <= 1, busy <= 0, return to IDLE.
  - done is low on every other edge.
- Latency:
  - Load accepted at edge t gives done=1 and a valid data_out after edge t+ROUNDS.
  - With ROUNDS=1, done follows the load edge by exactly one cycle.
- load while busy=1 is ignored:
  - captured values, counter and output are unaffected;
  - the request is not queued.
- Back-to-back operation:
  - ready is high in the done cycle, so a load sampled at the next edge is accepted.
  - Sustained throughput is one block per ROUNDS+1 cycles.
- Inputs are sampled only at the accepted load edge; changing data_in, key_in or decrypt during RUN has no effect.
- Decrypt(Encrypt(x,k),k) = x for all x, k, WIDTH and ROUNDS.

Test Plan:
1. WIDTH=8, ROUNDS=2, key 0x01, data 0x80, encrypt, load at edge 0:
   - busy=1 after edge 0;
   - done=1 and data_out=0x02 after edge 2;
   - busy=0 in the same cycle.
2. Same parameters, decrypt, data 0x02, key 0x01:
   - data_out=0x80 with done after 2 cycles;
   - done is a single-cycle pulse.
3. Defaults (64/16), 200 random (x,k) pairs, encrypt then decrypt the result:
   - every pair recovers x;
   - every done occurs exactly 16 cycles after its load edge.
4. Defaults, load held high continuously with changing data_in:
   - only loads with busy=0 are accepted, one per 17 cycles;
   - results match the model computed from the values captured at acceptance.
5. Defaults, assert reset at round 7 of a block:
   - after the reset edge, busy=0, done=0, data_out=0;
   - no done appears later.
   - A following load of key 0, data 0 encrypts to data_out=0.
6. WIDTH=4, ROUNDS=9 (key wraps):
   - key 0x1, data 0x0 encrypt/decrypt round-trip succeeds;
   - data_out matches the reference model with k_i = rotl(key, i mod 4).
